fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem request, presents a word to decode, redirects on consume.
// Latency 2 cycles fetch-to-issue minimum; backpressure: imem_ready=0 holds the request, stall holds instr/pc.
module fetch_unit #(
  parameter int                    Data_Width = 32,
  parameter logic [Data_Width-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [Data_Width-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [Data_Width-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [Data_Width-1:0] branch_target,
  input  logic                  jalr_sel,
  input  logic [Data_Width-1:0] jalr_target,
  output logic                  instr_valid,
  output logic [Data_Width-1:0] instr,
  output logic [Data_Width-1:0] pc,
  output logic [Data_Width-1:0] pc_plus4,
  output logic                  misaligned,
  output logic [31:0]           instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALT} state_t;

  localparam logic [Data_Width-1:0] NOP       = Data_Width'(32'h0000_0013);
  localparam logic [Data_Width-1:0] WORD      = Data_Width'(4);
  localparam logic [Data_Width-1:0] LSB_CLEAR = ~Data_Width'(1);

  state_t                state;
  logic [Data_Width-1:0] fetch_pc;
  logic [Data_Width-1:0] next_pc;
  logic                  redirect;
  logic                  bad_target;

  assign imem_addr = fetch_pc;
  assign pc_plus4  = pc + WORD;

  // jalr wins over a taken branch; only redirects can land off a word boundary
  always_comb begin
    redirect = 1'b0;
    next_pc  = pc_plus4;
    if (jalr_sel) begin
      redirect = 1'b1;
      next_pc  = jalr_target & LSB_CLEAR;
    end else if (branch_taken) begin
      redirect = 1'b1;
      next_pc  = branch_target;
    end
    bad_target = redirect && (next_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      misaligned  <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            instr_count <= instr_count + 32'd1;
            instr_valid <= 1'b0;
            if (bad_target) begin
              misaligned <= 1'b1;
              state      <= HALT;
            end else begin
              fetch_pc <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
